pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It generates the load-enable and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, EX-stage redirects (taken branch or jump) and data-memory wait states, and applies a timeout abort to memory waits. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 15: maximum frozen cycles for one data-memory access; must be ≥2.
- WDSEL_LOAD, 2'b01: WDSel encoding that marks a load (write-back from memory).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  each is 1 when the ID instruction reads the matching source.
- ex_valid  in  1  ID/EX running bit.
- ex_rfwr  in  1  ID/EX RFWr.
- ex_wdsel  in  2  ID/EX WDSel.
- ex_rd  in  5  ID/EX destination register.
- ex_redirect  in  1  EX has resolved a taken branch or a jump.
- mem_req  in  1  EX/MEM holds a valid load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register load enables.
- ifid_flush, idex_flush  out  1  load the stage with running=0; a flush takes precedence over its enable.
- mem_err  out  1  one-cycle registered pulse after a memory timeout.
- stall_cnt  out  32  cycles with pc_en=0, saturating.
- flush_cnt  out  32  redirects acted on, saturating.

## Operation
- FSM states are RUN and MWAIT. The reset state is RUN.
- The wait counter wcnt is $clog2(MEM_TIMEOUT) bits wide.
- All enables and flushes are combinational (Mealy) from state and inputs.
- Hazard terms:
  - memstall = mem_req & ~mem_ready
  - loaduse = ex_valid & ex_rfwr & (ex_wdsel==WDSEL_LOAD) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - release = MWAIT & (mem_ready | wcnt==MEM_TIMEOUT-1)
- Outputs, in priority order:
  1. Frozen (RUN&memstall, or MWAIT&~release): all enables 0, flushes 0.
  2. Redirect (ex_redirect): all enables 1, ifid_flush=1, idex_flush=1. Redirect beats loaduse because the ID instruction is squashed anyway.
  3. Load-use (loaduse): pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
  4. Otherwise: all enables 1, flushes 0.
- On a release cycle, priorities 2–4 are evaluated normally. Held ex_redirect and loaduse values act then.
- Transitions:
  - RUN → MWAIT on memstall; wcnt ← 0.
  - MWAIT → RUN on release. On timeout release (wcnt==MEM_TIMEOUT-1 & ~mem_ready), the access is aborted, the pipeline advances, and mem_err ← 1 for the next cycle.
  - MWAIT & ~release: wcnt ← wcnt+1.
- Counters:
  - stall_cnt +1 on every cycle with pc_en=0 while out of reset.
  - flush_cnt +1 on every cycle in which the redirect outputs are driven.
  - Both hold at 32'hFFFF_FFFF.
- While rst=0: all enables 0, flushes 0, mem_err 0.

## Timing
- Reset (async, rst low): state=RUN, wcnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. Reset during MWAIT aborts the wait without a mem_err.
- Hazard response is zero-latency (same cycle). mem_err asserts one cycle after the timeout release cycle and lasts exactly one cycle.
- Memory wait:
  - An access ready on its first cycle costs 0 stall cycles.
  - Ready after k frozen cycles (k < MEM_TIMEOUT) costs k stall cycles, released in cycle k.
  - Timeout: frozen exactly MEM_TIMEOUT cycles; release on the next cycle.
- Load-use costs exactly 1 bubble. On the following cycle the load has left ID/EX, so loaduse=0.
- Simultaneous events:
  - memstall beats redirect and loaduse.
  - mem_ready on the entry cycle (RUN) means no stall.
  - mem_ready on the timeout cycle counts as a normal release: no mem_err.

## Test plan
- Load x5 in EX (ex_wdsel=WDSEL_LOAD, ex_rd=5), ID reads rs1=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1; next cycle all enables 1.
- Same as above but ex_rd=0, or id_use_rs1=0 → no stall; stall_cnt stays 0.
- ex_redirect=1 together with a load-use hit → ifid_flush=idex_flush=1, pc_en=1, no stall; flush_cnt=1.
- mem_req=1, mem_ready rises 3 cycles later → all enables 0 for cycles 0–2, released in cycle 3; stall_cnt=3; mem_err stays 0.
- mem_req=1, mem_ready never rises, MEM_TIMEOUT=15 → 15 frozen cycles, release on cycle 15, mem_err pulse on cycle 16 only; stall_cnt=15.
- rst pulsed low in MWAIT (wcnt=4) → outputs and counters 0 immediately, state RUN; after rst goes high with mem_ready=1, no mem_err.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencing: stalls, bubbles and redirect flushes.
// Memory waits are bounded by a timeout that aborts the access.
module pipe_ctrl #(
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [1:0]  WDSEL_LOAD  = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_valid,
    input  logic        ex_rfwr,
    input  logic [1:0]  ex_wdsel,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] W_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MWAIT
    } state_t;

    state_t        r_state;
    logic [WW-1:0] r_wcnt;
    logic          r_mem_err;
    logic [31:0]   r_stall_cnt;
    logic [31:0]   r_flush_cnt;

    logic w_memstall;
    logic w_hit1;
    logic w_hit2;
    logic w_loaduse;
    logic w_tmo;
    logic w_release;
    logic w_frozen;
    logic w_redir_act;

    assign w_memstall = mem_req & ~mem_ready;
    assign w_hit1 = id_use_rs1 & (id_rs1 == ex_rd);
    assign w_hit2 = id_use_rs2 & (id_rs2 == ex_rd);
    assign w_loaduse = ex_valid & ex_rfwr & (ex_wdsel == WDSEL_LOAD)
                     & (ex_rd != 5'd0) & (w_hit1 | w_hit2);
    assign w_tmo = (r_wcnt == W_LAST);
    assign w_release = (r_state == MWAIT) & (mem_ready | w_tmo);
    assign w_frozen = ((r_state == RUN) & w_memstall)
                    | ((r_state == MWAIT) & ~w_release);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        w_redir_act = 1'b0;
        if (!rst || w_frozen) begin
            pc_en = 1'b0;
        end else if (ex_redirect) begin
            // ID is squashed by the redirect, so its load-use hit is moot
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_redir_act = 1'b1;
        end else if (w_loaduse) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_wcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (w_memstall) begin
                        r_state <= MWAIT;
                        r_wcnt  <= '0;
                    end
                end
                MWAIT: begin
                    if (w_release) begin
                        r_state   <= RUN;
                        r_mem_err <= ~mem_ready;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_redir_act && r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
